// File: rtl/hpdmc_ddr_wrburst.sv
// hpdmc_ddr_wrburst: write-burst sequencer driving DQ/DM/DQS ODDR2 inputs with preamble, data and postamble.
// Registered ODDR inputs are computed from the next state so they line up with the state they describe.
module hpdmc_ddr_wrburst #(
    parameter int DQ_WIDTH   = 16,
    parameter int BURST_LEN  = 4,
    parameter int WR_LATENCY = 1
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic                    wr_start,
    input  logic [2*DQ_WIDTH-1:0]   wr_data,
    input  logic [DQ_WIDTH/4-1:0]   wr_mask,
    input  logic                    wr_data_valid,
    output logic                    wr_data_ready,
    output logic [DQ_WIDTH-1:0]     dq_d0,
    output logic [DQ_WIDTH-1:0]     dq_d1,
    output logic [DQ_WIDTH/8-1:0]   dm_d0,
    output logic [DQ_WIDTH/8-1:0]   dm_d1,
    output logic                    dqs_d0,
    output logic                    dqs_d1,
    output logic                    dq_oe,
    output logic                    dqs_oe,
    output logic                    busy,
    output logic                    underrun,
    output logic                    cmd_err
);
    localparam int NB = DQ_WIDTH / 8;
    localparam logic [2:0] WL_LAST = 3'(WR_LATENCY - 1);
    localparam logic [2:0] BL_LAST = 3'(BURST_LEN / 2 - 1);

    typedef enum logic [2:0] {IDLE, WAIT, PRE, DATA, POST} state_t;

    state_t state_q, state_d;
    logic [2:0] wait_q, wait_d, beat_q, beat_d;
    logic [DQ_WIDTH-1:0] dq0_q, dq0_d, dq1_q, dq1_d;
    logic [NB-1:0] dm0_q, dm0_d, dm1_q, dm1_d;
    logic dqs_oe_q, dqs_oe_d, dq_oe_q, dq_oe_d, dqs0_q, dqs0_d;
    logic underrun_q, underrun_d, cmd_err_q, cmd_err_d;

    assign busy          = state_q != IDLE;
    assign wr_data_ready = (state_q == PRE) || (state_q == DATA && beat_q != BL_LAST);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: if (wr_start) begin
                state_d = (WR_LATENCY != 0) ? WAIT : PRE;
                wait_d  = 3'd0;
            end
            WAIT: begin
                state_d = (wait_q == WL_LAST) ? PRE : WAIT;
                wait_d  = (wait_q == WL_LAST) ? 3'd0 : wait_q + 3'd1;
            end
            PRE:  state_d = DATA;
            DATA: begin
                state_d = (beat_q == BL_LAST) ? POST : DATA;
                beat_d  = (beat_q == BL_LAST) ? 3'd0 : beat_q + 3'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready implies the next state is DATA; POST holds the last beat on the pads.
    always_comb begin
        dq0_d      = wr_data_ready ? (wr_data_valid ? wr_data[DQ_WIDTH-1:0] : '0)
                                   : (state_d == POST ? dq0_q : '0);
        dq1_d      = wr_data_ready ? (wr_data_valid ? wr_data[2*DQ_WIDTH-1:DQ_WIDTH] : '0)
                                   : (state_d == POST ? dq1_q : '0);
        dm0_d      = wr_data_ready ? (wr_data_valid ? wr_mask[NB-1:0] : '1)
                                   : (state_d == POST ? dm0_q : '0);
        dm1_d      = wr_data_ready ? (wr_data_valid ? wr_mask[2*NB-1:NB] : '1)
                                   : (state_d == POST ? dm1_q : '0);
        dqs_oe_d   = state_d == PRE || state_d == DATA || state_d == POST;
        dq_oe_d    = state_d == DATA || state_d == POST;
        dqs0_d     = state_d == DATA;
        underrun_d = underrun_q || (wr_data_ready && !wr_data_valid);
        cmd_err_d  = cmd_err_q || (wr_start && busy);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            beat_q     <= '0;
            dq0_q      <= '0;
            dq1_q      <= '0;
            dm0_q      <= '0;
            dm1_q      <= '0;
            dqs_oe_q   <= 1'b0;
            dq_oe_q    <= 1'b0;
            dqs0_q     <= 1'b0;
            underrun_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            beat_q     <= beat_d;
            dq0_q      <= dq0_d;
            dq1_q      <= dq1_d;
            dm0_q      <= dm0_d;
            dm1_q      <= dm1_d;
            dqs_oe_q   <= dqs_oe_d;
            dq_oe_q    <= dq_oe_d;
            dqs0_q     <= dqs0_d;
            underrun_q <= underrun_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    assign dq_d0    = dq0_q;
    assign dq_d1    = dq1_q;
    assign dm_d0    = dm0_q;
    assign dm_d1    = dm1_q;
    assign dqs_d0   = dqs0_q;
    assign dqs_d1   = 1'b0;
    assign dqs_oe   = dqs_oe_q;
    assign dq_oe    = dq_oe_q;
    assign underrun = underrun_q;
    assign cmd_err  = cmd_err_q;
endmodule

// File: tb/tb_hpdmc_ddr_wrburst.sv
// tb_hpdmc_ddr_wrburst: directed vector bench for the write-burst sequencer.
// Main instance uses WR_LATENCY=1/BURST_LEN=4; a second uses WR_LATENCY=0/BURST_LEN=8.
module tb_hpdmc_ddr_wrburst;
    logic clk = 1'b0, rst_n = 1'b0;
    logic start = 1'b0, valid = 1'b0, start2 = 1'b0, valid2 = 1'b0;
    logic [31:0] data = '0, data2 = '0;
    logic [3:0] mask = '0;
    logic rdy, bsy, sd0, sd1, qoe, soe, ur, ce;
    logic [15:0] q0, q1;
    logic [1:0] m0, m1;
    logic rdy2, bsy2, sd0_2, sd1_2, qoe2, soe2, ur2, ce2;
    logic [15:0] q0_2, q1_2;
    logic [1:0] m0_2, m1_2;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    hpdmc_ddr_wrburst #(.DQ_WIDTH(16), .BURST_LEN(4), .WR_LATENCY(1)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .wr_start(start), .wr_data(data), .wr_mask(mask),
        .wr_data_valid(valid), .wr_data_ready(rdy), .dq_d0(q0), .dq_d1(q1), .dm_d0(m0), .dm_d1(m1),
        .dqs_d0(sd0), .dqs_d1(sd1), .dq_oe(qoe), .dqs_oe(soe), .busy(bsy), .underrun(ur), .cmd_err(ce));

    hpdmc_ddr_wrburst #(.DQ_WIDTH(16), .BURST_LEN(8), .WR_LATENCY(0)) dut2 (
        .sys_clk(clk), .sys_rst_n(rst_n), .wr_start(start2), .wr_data(data2), .wr_mask(4'b0000),
        .wr_data_valid(valid2), .wr_data_ready(rdy2), .dq_d0(q0_2), .dq_d1(q1_2), .dm_d0(m0_2), .dm_d1(m1_2),
        .dqs_d0(sd0_2), .dqs_d1(sd1_2), .dq_oe(qoe2), .dqs_oe(soe2), .busy(bsy2), .underrun(ur2), .cmd_err(ce2));

    // fl = {busy, ready, dqs_oe, dq_oe, dqs_d0, underrun, cmd_err}; dm = {dm_d1, dm_d0}
    typedef struct {
        logic [1:0]  sv;
        logic [31:0] d;
        logic [3:0]  m;
        logic [6:0]  fl;
        logic [15:0] q0, q1;
        logic [3:0]  dm;
    } vec_t;
    vec_t v [19];

    localparam logic [31:0] A = 32'hB0B1_A0A1;
    localparam logic [31:0] B = 32'hD0D1_C0C1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            {start, valid} = v[i].sv;
            data = v[i].d;
            mask = v[i].m;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d flags", i), 32'({bsy, rdy, soe, qoe, sd0, ur, ce}), 32'(v[i].fl));
            chk($sformatf("row%0d dq_d0", i), 32'(q0), 32'(v[i].q0));
            chk($sformatf("row%0d dq_d1", i), 32'(q1), 32'(v[i].q1));
            chk($sformatf("row%0d dm", i), 32'({m1, m0}), 32'(v[i].dm));
            chk($sformatf("row%0d dqs_d1", i), 32'(sd1), 32'h0);
        end
        {start, valid} = 2'b00;
    endtask

    initial begin
        v[0]  = '{2'b10, 32'h0, 4'h0, 7'b1000000, 16'h0,    16'h0,    4'h0};
        v[1]  = '{2'b00, 32'h0, 4'h0, 7'b1110000, 16'h0,    16'h0,    4'h0};
        v[2]  = '{2'b01, A,     4'h6, 7'b1111100, 16'hA0A1, 16'hB0B1, 4'h6};
        v[3]  = '{2'b01, B,     4'h0, 7'b1011100, 16'hC0C1, 16'hD0D1, 4'h0};
        v[4]  = '{2'b00, 32'h0, 4'h0, 7'b1011000, 16'hC0C1, 16'hD0D1, 4'h0};
        v[5]  = '{2'b00, 32'h0, 4'h0, 7'b0000000, 16'h0,    16'h0,    4'h0};
        v[6]  = '{2'b10, 32'h0, 4'h0, 7'b1000000, 16'h0,    16'h0,    4'h0};
        v[7]  = '{2'b00, 32'h0, 4'h0, 7'b1110000, 16'h0,    16'h0,    4'h0};
        v[8]  = '{2'b01, A,     4'h6, 7'b1111100, 16'hA0A1, 16'hB0B1, 4'h6};
        v[9]  = '{2'b00, B,     4'h0, 7'b1011110, 16'h0,    16'h0,    4'hF};
        v[10] = '{2'b00, 32'h0, 4'h0, 7'b1011010, 16'h0,    16'h0,    4'hF};
        v[11] = '{2'b00, 32'h0, 4'h0, 7'b0000010, 16'h0,    16'h0,    4'h0};
        v[12] = '{2'b10, 32'h0, 4'h0, 7'b1000010, 16'h0,    16'h0,    4'h0};
        v[13] = '{2'b00, 32'h0, 4'h0, 7'b1110010, 16'h0,    16'h0,    4'h0};
        v[14] = '{2'b01, A,     4'h6, 7'b1111110, 16'hA0A1, 16'hB0B1, 4'h6};
        v[15] = '{2'b11, B,     4'h0, 7'b1011111, 16'hC0C1, 16'hD0D1, 4'h0};
        v[16] = '{2'b10, 32'h0, 4'h0, 7'b1011011, 16'hC0C1, 16'hD0D1, 4'h0};
        v[17] = '{2'b10, 32'h0, 4'h0, 7'b0000011, 16'h0,    16'h0,    4'h0};
        v[18] = '{2'b00, 32'h0, 4'h0, 7'b0000011, 16'h0,    16'h0,    4'h0};

        #7;
        chk("reset held outputs", 32'({bsy, rdy, soe, qoe, sd0, sd1, ur, ce, q0, m0, m1}), 32'h0);
        chk("reset held dq_d1", 32'(q1), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post reset outputs", 32'({bsy, rdy, soe, qoe, sd0, sd1, ur, ce, q0, m0, m1}), 32'h0);
        chk("post reset busy2", 32'({bsy2, soe2, qoe2}), 32'h0);

        run_rows(0, 18);

        // Asynchronous reset in the middle of DATA
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 {valid, data, mask} = {1'b1, A, 4'h0};
        @(posedge clk);
        #1 valid = 1'b0;
        chk("in DATA before reset", 32'({bsy, soe, qoe}), 32'h7);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset enables", 32'({bsy, soe, qoe, sd0}), 32'h0);
        chk("async reset sticky", 32'({ur, ce}), 32'h0);
        chk("async reset dq", 32'(q0), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_rows(0, 5);

        // Zero-latency, 8-beat instance
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        chk("bl8 PRE", 32'({bsy2, rdy2, soe2, qoe2, sd0_2}), 32'h1C);
        for (int k = 0; k < 4; k++) begin
            valid2 = 1'b1;
            data2 = {16'h5500 + 16'(k), 16'h1100 + 16'(k)};
            @(posedge clk);
            #1;
            chk($sformatf("bl8 beat%0d strobe", k), 32'({soe2, qoe2, sd0_2, sd1_2}), 32'hE);
            chk($sformatf("bl8 beat%0d data", k), {q1_2, q0_2}, {16'h5500 + 16'(k), 16'h1100 + 16'(k)});
            chk($sformatf("bl8 beat%0d ready", k), 32'(rdy2), (k < 3) ? 32'h1 : 32'h0);
        end
        valid2 = 1'b0;
        @(posedge clk);
        #1;
        chk("bl8 POST", 32'({bsy2, rdy2, soe2, qoe2, sd0_2, ur2, ce2}), 32'h58);
        chk("bl8 POST hold", {q1_2, q0_2}, 32'h5503_1103);
        @(posedge clk);
        #1;
        chk("bl8 IDLE", 32'({bsy2, soe2, qoe2, q0_2}), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hpdmc_ddr_wrburst.md
Name: hpdmc_ddr_wrburst

Overview:
- Write-burst launch sequencer feeding a DQ_WIDTH-wide bank of ODDR2 cells plus the DQS and DM ODDR2 cells.
- Accepts one write command, waits a programmable write latency, then drives DQS preamble, data and postamble. It supplies per-cycle D0/D1 pairs and output enables for the DQ and DQS pads.
- Sits between the HPDMC data path and the Spartan-6 DDR I/O primitives, and replaces hand-wired per-bit ODDR2 data handling.

Parameters:
- DQ_WIDTH, 16, DQ pad width; must be a multiple of 8.
- BURST_LEN, 4, beats per burst; even, 2..16. The DATA phase lasts BURST_LEN/2 cycles.
- WR_LATENCY, 1, idle cycles between the command and the preamble; 0..7.

Ports:
- sys_clk  in  1  single system clock; all state on the rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- wr_start  in  1  write command strobe; one cycle.
- wr_data  in  2*DQ_WIDTH  beat pair: [DQ_WIDTH-1:0] is the rising beat (D0), the upper half is the falling beat (D1).
- wr_mask  in  DQ_WIDTH/4  byte masks: lower DQ_WIDTH/8 bits for D0, upper bits for D1; 1 = masked.
- wr_data_valid  in  1  upstream has wr_data/wr_mask available.
- wr_data_ready  out  1  block consumes wr_data this cycle if valid.
- dq_d0, dq_d1  out  DQ_WIDTH each  DQ ODDR2 inputs.
- dm_d0, dm_d1  out  DQ_WIDTH/8 each  DM ODDR2 inputs.
- dqs_d0, dqs_d1  out  1 each  DQS ODDR2 inputs.
- dq_oe  out  1  DQ/DM pad output enable.
- dqs_oe  out  1  DQS pad output enable.
- busy  out  1  high whenever state != IDLE.
- underrun  out  1  sticky: a DATA cycle had no valid data.
- cmd_err  out  1  sticky: wr_start arrived while busy.

Behaviour:
- Reset, asynchronous on sys_rst_n low, including mid-burst:
  - state goes to IDLE.
  - All outputs go to 0, including the sticky flags.
  - Counters clear.
  - A burst is abandoned with no postamble.
- All outputs except wr_data_ready and busy are registered. wr_data_ready and busy decode only the registered state and counter.
- States and transitions:
  - IDLE: on wr_start, go to WAIT if WR_LATENCY > 0, otherwise to PRE.
  - WAIT: a 3-bit counter runs WR_LATENCY cycles, then goes to PRE.
  - PRE: 1 cycle, then DATA.
  - DATA: exactly BURST_LEN/2 cycles, counted by a beat counter, then POST.
  - POST: 1 cycle, then IDLE.
- Cycle timing: wr_start is sampled at edge T.
  - PRE occupies cycle T+WR_LATENCY+1.
  - DATA occupies the next BURST_LEN/2 cycles.
  - POST follows DATA.
  - busy is high from T+1 through POST.
- Outputs per state:
  - PRE: dqs_oe=1, dqs_d0=0, dqs_d1=0, dq_oe=0.
  - DATA: dqs_oe=1, dqs_d0=1, dqs_d1=0, dq_oe=1.
  - POST: dqs_oe=1, dqs_d0=0, dqs_d1=0, dq_oe=1; dq and dm hold their last DATA values.
  - IDLE/WAIT: both enables are 0, dq/dm/dqs data are 0.
- Data handshake:
  - wr_data_ready is high in PRE and in every DATA cycle except the last.
  - Data accepted at an edge appears on dq_d0/dq_d1/dm_* during the following DATA cycle. Latency from acceptance to the ODDR input is 1 cycle.
  - Exactly BURST_LEN/2 transfers are requested per burst.
- Underrun: if wr_data_ready=1 and wr_data_valid=0, the next DATA cycle drives dq=0 and dm all-ones on both phases, and underrun sets. The burst continues; timing is unchanged.
- Command while busy: a wr_start sampled while busy=1 is dropped and cmd_err sets. A wr_start in the POST cycle is also dropped. Back-to-back bursts need one IDLE cycle.
- Sticky flags clear only on reset.
- The beat counter wraps to 0 on exit from DATA.

Test Plan:
- Reset with DQ_WIDTH=16, BURST_LEN=4, WR_LATENCY=1: hold sys_rst_n=0, then release. Required: all outputs 0, busy=0.
- wr_start at T with valid data A then B:
  - T+1: WAIT.
  - T+2: PRE, dqs_oe=1.
  - T+3: DATA with dq_d0/dq_d1 = A halves.
  - T+4: DATA with B halves.
  - T+5: POST with B held.
  - T+6: IDLE, all 0.
- WR_LATENCY=0, BURST_LEN=8: PRE at T+1; 4 DATA cycles with dqs_d0=1, dqs_d1=0; wr_data_ready high for 4 cycles.
- wr_data_valid low for the 2nd beat: that DATA cycle has dq=0 and dm_d0=dm_d1=2'b11, and underrun=1 persists; the remaining beats are normal.
- wr_start pulsed during DATA and again during POST: no effect on the running burst; cmd_err=1; busy drops on schedule.
- sys_rst_n pulsed low during DATA: dqs_oe, dq_oe and busy go to 0 immediately (asynchronous). A subsequent wr_start runs a full, correct burst.
